// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back / write-allocate data cache controller.
// A miss stalls the pipeline while the victim line is written out and the new line is read in.
module dcache_ctrl #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [3:0]  wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_rd_req,
    output logic        mem_wr_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_gnt
);

    localparam int TAG_LEN    = 32 - SET_ADDR_LEN - LINE_ADDR_LEN - 2;
    localparam int LINE_WORDS = 1 << LINE_ADDR_LEN;
    localparam int SETS       = 1 << SET_ADDR_LEN;
    localparam logic [LINE_ADDR_LEN-1:0] LAST_WORD = '1;

    typedef enum logic [1:0] {
        IDLE,
        SWAP_OUT,
        SWAP_IN,
        SWAP_IN_OK
    } state_t;

    state_t                   state_q, state_d;
    logic [LINE_ADDR_LEN-1:0] cnt_q, cnt_d;

    logic [SETS-1:0]          valid_q;
    logic [SETS-1:0]          dirty_q;
    logic [TAG_LEN-1:0]       tag_q  [SETS];
    logic [31:0]              data_q [SETS][LINE_WORDS];

    logic [LINE_ADDR_LEN-1:0] req_off;
    logic [SET_ADDR_LEN-1:0]  req_set;
    logic [TAG_LEN-1:0]       req_tag;
    logic                     req_any;
    logic                     is_store;
    logic                     hit;
    logic                     victim_dirty;
    logic                     store_we;
    logic                     fill_we;
    logic                     line_done;
    logic                     unused_addr_lsb;

    assign req_off  = addr[LINE_ADDR_LEN+1:2];
    assign req_set  = addr[SET_ADDR_LEN+LINE_ADDR_LEN+1:LINE_ADDR_LEN+2];
    assign req_tag  = addr[31:32-TAG_LEN];
    assign unused_addr_lsb = ^addr[1:0];

    assign is_store     = |wr_req;
    assign req_any      = rd_req | is_store;
    assign hit          = valid_q[req_set] && (tag_q[req_set] == req_tag);
    assign victim_dirty = valid_q[req_set] && dirty_q[req_set];

    // The word path carries no reset, so the output is forced low while reset is held.
    assign rd_data = rst ? 32'h0 : data_q[req_set][req_off];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        miss        = 1'b0;
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        mem_addr    = 32'h0;
        mem_wr_data = 32'h0;
        store_we    = 1'b0;
        fill_we     = 1'b0;
        line_done   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    if (hit) begin
                        store_we = is_store;
                    end else begin
                        miss    = 1'b1;
                        state_d = victim_dirty ? SWAP_OUT : SWAP_IN;
                    end
                end
            end
            SWAP_OUT: begin
                miss        = 1'b1;
                mem_wr_req  = 1'b1;
                mem_addr    = {tag_q[req_set], req_set, cnt_q, 2'b00};
                mem_wr_data = data_q[req_set][cnt_q];
                if (mem_gnt) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d = SWAP_IN;
                    end
                end
            end
            SWAP_IN: begin
                miss       = 1'b1;
                mem_rd_req = 1'b1;
                mem_addr   = {req_tag, req_set, cnt_q, 2'b00};
                if (mem_gnt) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        state_d = SWAP_IN_OK;
                    end
                end
            end
            SWAP_IN_OK: begin
                miss      = 1'b1;
                line_done = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            miss      = 1'b0;
            store_we  = 1'b0;
            fill_we   = 1'b0;
            line_done = 1'b0;
        end
    end

    // A line being refilled is invalid until its last word lands, so an abort never leaves it valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_done) begin
            valid_q[req_set] <= 1'b1;
            dirty_q[req_set] <= 1'b0;
        end else if (fill_we) begin
            valid_q[req_set] <= 1'b0;
        end else if (store_we) begin
            dirty_q[req_set] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_q[req_set][cnt_q] <= mem_rd_data;
        end
        for (int b = 0; b < 4; b++) begin
            if (store_we && wr_req[b]) begin
                data_q[req_set][req_off][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
        if (line_done) begin
            tag_q[req_set] <= req_tag;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a word-granular main-memory responder.
// Memory word i initially holds i*4, so every fill word equals its own byte address.
module tb_dcache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req;
    logic [3:0]  wr_req;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        miss;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        mem_gnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mem [1024];
    logic [31:0] rd_log [$];
    logic [31:0] wr_a [$];
    logic [31:0] wr_d [$];
    int          gnt_delay = 0;
    bit          chk_slow  = 1'b0;
    bit          spurious  = 1'b0;

    dcache_ctrl #(.LINE_ADDR_LEN(3), .SET_ADDR_LEN(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_req      (rd_req),
        .wr_req      (wr_req),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .miss        (miss),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .mem_gnt     (mem_gnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: grants a pending request after gnt_delay idle cycles.
    initial begin
        int          wait_cnt;
        logic [31:0] hold;
        wait_cnt    = 0;
        hold        = 32'h0;
        mem_gnt     = 1'b0;
        mem_rd_data = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt = 1'b0;
            if (rst || !(mem_rd_req || mem_wr_req)) begin
                wait_cnt = 0;
                if (spurious && !rst) mem_gnt = 1'b1;
            end else begin
                check("excl", 32'(mem_rd_req & mem_wr_req), 32'h0);
                if (wait_cnt == 0) begin
                    hold = mem_addr;
                end else if (chk_slow) begin
                    check("slow_addr", mem_addr, hold);
                    check("slow_miss", 32'(miss), 32'h1);
                end
                if (wait_cnt < gnt_delay) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    mem_gnt  = 1'b1;
                    if (mem_rd_req) begin
                        mem_rd_data = mem[mem_addr[11:2]];
                        rd_log.push_back(mem_addr);
                    end else begin
                        mem[mem_addr[11:2]] = mem_wr_data;
                        wr_a.push_back(mem_addr);
                        wr_d.push_back(mem_wr_data);
                    end
                end
            end
        end
    end

    task automatic do_load(input logic [31:0] a, input logic exp_miss,
                           input logic [31:0] exp_d, input string tag);
        int n;
        addr   = a;
        rd_req = 1'b1;
        wr_req = 4'h0;
        #1;
        check({tag, "_miss0"}, 32'(miss), 32'(exp_miss));
        n = 0;
        while (miss && n < 500) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({tag, "_done"}, 32'(miss), 32'h0);
        check({tag, "_data"}, rd_data, exp_d);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] d, input logic rd, input string tag);
        addr    = a;
        wr_req  = be;
        wr_data = d;
        rd_req  = rd;
        #1;
        check({tag, "_miss"}, 32'(miss), 32'h0);
        @(posedge clk);
        #1;
        wr_req = 4'h0;
        rd_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        rst     = 1'b1;
        rd_req  = 1'b1;
        wr_req  = 4'h0;
        addr    = 32'h40;
        wr_data = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 4);

        repeat (2) @(posedge clk);
        #2;
        check("rst_miss", 32'(miss), 32'h0);
        check("rst_rdata", rd_data, 32'h0);
        check("rst_mrd", 32'(mem_rd_req), 32'h0);
        check("rst_mwr", 32'(mem_wr_req), 32'h0);
        check("rst_maddr", mem_addr, 32'h0);
        check("rst_mwdata", mem_wr_data, 32'h0);
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("idle_miss", 32'(miss), 32'h0);
        @(posedge clk);
        #1;

        do_load(32'h40, 1'b1, 32'h40, "cold");
        check("cold_nrd", 32'(rd_log.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("cold_rd%0d", i), rd_log[i], 32'h40 + 32'(4 * i));
        check("cold_nwr", 32'(wr_a.size()), 32'd0);

        do_store(32'h44, 4'hF, 32'hDEADBEEF, 1'b0, "sw44");
        do_load(32'h44, 1'b0, 32'hDEADBEEF, "lw44");
        do_load(32'h48, 1'b0, 32'h48, "lw48");
        check("hit_nrd", 32'(rd_log.size()), 32'd8);

        do_load(32'h440, 1'b1, 32'h440, "evict");
        check("evict_nwr", 32'(wr_a.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("evict_wa%0d", i), wr_a[i], 32'h40 + 32'(4 * i));
            check($sformatf("evict_wd%0d", i), wr_d[i],
                  (i == 1) ? 32'hDEADBEEF : 32'h40 + 32'(4 * i));
        end
        check("evict_nrd", 32'(rd_log.size()), 32'd16);
        for (int i = 0; i < 8; i++)
            check($sformatf("evict_rd%0d", i), rd_log[8 + i], 32'h440 + 32'(4 * i));

        do_load(32'h44, 1'b1, 32'hDEADBEEF, "refill");
        check("refill_nwr", 32'(wr_a.size()), 32'd8);
        check("refill_nrd", 32'(rd_log.size()), 32'd24);

        do_store(32'h40, 4'hF, 32'h11223344, 1'b0, "sw40");
        do_store(32'h42, 4'b0100, 32'h00AB0000, 1'b0, "sb42");
        do_load(32'h40, 1'b0, 32'h11AB3344, "lb40");

        do_store(32'h48, 4'hF, 32'hCAFEF00D, 1'b1, "rdwr");
        do_load(32'h48, 1'b0, 32'hCAFEF00D, "lw48b");

        spurious = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #2;
            check("spur_miss", 32'(miss), 32'h0);
            check("spur_mreq", 32'(mem_rd_req | mem_wr_req), 32'h0);
        end
        spurious = 1'b0;
        @(posedge clk);
        #1;
        check("spur_nrd", 32'(rd_log.size()), 32'd24);
        do_load(32'h48, 1'b0, 32'hCAFEF00D, "post_spur");

        gnt_delay = 5;
        chk_slow  = 1'b1;
        do_load(32'h80, 1'b1, 32'h80, "slow");
        chk_slow  = 1'b0;
        gnt_delay = 0;
        check("slow_nrd", 32'(rd_log.size()), 32'd32);
        check("slow_nwr", 32'(wr_a.size()), 32'd8);

        gnt_delay = 2;
        base   = rd_log.size();
        addr   = 32'hC0;
        rd_req = 1'b1;
        n = 0;
        while (rd_log.size() < base + 3 && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("abort_3w", 32'(rd_log.size()), 32'(base + 3));
        @(posedge clk);
        #1;
        check("abort_maddr", mem_addr, 32'hCC);
        check("abort_mrd", 32'(mem_rd_req), 32'h1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_mrd0", 32'(mem_rd_req), 32'h0);
        check("abort_mwr0", 32'(mem_wr_req), 32'h0);
        check("abort_maddr0", mem_addr, 32'h0);
        check("abort_miss0", 32'(miss), 32'h0);
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        gnt_delay = 0;
        @(posedge clk);
        #1;
        do_load(32'hC0, 1'b1, 32'hC0, "reload");
        do_load(32'h40, 1'b1, 32'h40, "post_rst40");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
